mem_split: RTL and testbench

Response-side router for the shared memory channel: accepts a single std_mem stream tagged with a port id and steers each transaction to the matching one of PORTS output std_mem interfaces. It is the counterpart of the request merger and sits between the memory/cache response path and the individual requesters. Each output port has a registered 2-entry buffer, so backpressure on one requester never creates a combinational path back to the shared channel.

---
 rtl/mem_split_if.sv | 26 ++
 rtl/mem_split.sv | 139 +++++++++++++
 tb/tb_mem_split.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_split_if.sv
// Shared memory-channel stream interface used by mem_split on both its tagged
// input side and its per-requester output side.
interface std_mem_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 1
);
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic [MASK_WIDTH-1:0] write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport master (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );

  modport slave (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );
endinterface

// File: rtl/mem_split.sv
// Response-side router: steers each tagged beat of the shared stream into a
// registered 2-entry FIFO per output port. Optional range check: MEM_SPLIT_ID_CHECK_EN.
module mem_split #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 1,
  parameter int PORTS      = 2
) (
  input  logic        clk,
  input  logic        rst,
  std_mem_intf.slave  mem_in,
  std_mem_intf.master mem_out [PORTS],
  output logic        id_error
);

  if (PORTS <= 1) begin : g_bad_ports
    $fatal(1, "mem_split: PORTS must be greater than 1");
  end
  if (ID_WIDTH < $clog2(PORTS)) begin : g_bad_id_width
    $fatal(1, "mem_split: ID_WIDTH too narrow for PORTS");
  end
  if ($bits(mem_in.addr) != ADDR_WIDTH || $bits(mem_in.data) != DATA_WIDTH ||
      $bits(mem_in.write_enable) != MASK_WIDTH || $bits(mem_in.id) != ID_WIDTH) begin : g_bad_in_width
    $fatal(1, "mem_split: mem_in field widths do not match parameters");
  end

  typedef struct packed {
    logic                  read_enable;
    logic [MASK_WIDTH-1:0] write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  // One extra bit so PORTS itself is representable when PORTS == 2**ID_WIDTH.
  localparam logic [ID_WIDTH:0] PORTS_W = (ID_WIDTH + 1)'(PORTS);

  entry_t           in_entry;
  logic             in_ready;
  logic             accept;
  logic             in_range;
  logic [PORTS-1:0] port_sel;
  logic [PORTS-1:0] port_full;

  assign in_entry = {mem_in.read_enable, mem_in.write_enable, mem_in.addr,
                     mem_in.data, mem_in.id};

  // Ready looks only at registered fill levels, so no requester's ready can
  // ripple back onto the shared channel.
  assign in_ready     = rst & ~(|port_full);
  assign mem_in.ready = in_ready;
  assign accept       = mem_in.valid & in_ready;

  always_comb begin
    in_range = ({1'b0, mem_in.id} < PORTS_W);
    port_sel = '0;
    for (int p = 0; p < PORTS; p++) begin
      if ({1'b0, mem_in.id} == (ID_WIDTH + 1)'(p)) begin
        port_sel[p] = 1'b1;
      end
    end
`ifndef MEM_SPLIT_ID_CHECK_EN
    if (!in_range) begin
      port_sel[0] = 1'b1;
    end
`endif
  end

  for (genvar k = 0; k < PORTS; k++) begin : g_port
    entry_t     buf_q [2];
    logic [1:0] cnt_q;
    logic       head_q;
    logic       tail_q;
    logic       push;
    logic       pop;
    logic       out_valid;

    if ($bits(mem_out[k].addr) != ADDR_WIDTH || $bits(mem_out[k].data) != DATA_WIDTH ||
        $bits(mem_out[k].write_enable) != MASK_WIDTH || $bits(mem_out[k].id) != ID_WIDTH) begin : g_bad_out_width
      $fatal(1, "mem_split: mem_out field widths do not match parameters");
    end

    assign push         = accept & port_sel[k];
    assign out_valid    = (cnt_q != 2'd0);
    assign pop          = out_valid & mem_out[k].ready;
    assign port_full[k] = (cnt_q == 2'd2);

    // Storage is cleared on reset too, so the payload reads as zero until the
    // first beat lands.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_q[0] <= '0;
        buf_q[1] <= '0;
        cnt_q    <= 2'd0;
        head_q   <= 1'b0;
        tail_q   <= 1'b0;
      end else begin
        if (push) begin
          buf_q[tail_q] <= in_entry;
          tail_q        <= ~tail_q;
        end
        if (pop) begin
          head_q <= ~head_q;
        end
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 2'd1;
          2'b01:   cnt_q <= cnt_q - 2'd1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign mem_out[k].valid        = out_valid;
    assign mem_out[k].read_enable  = buf_q[head_q].read_enable;
    assign mem_out[k].write_enable = buf_q[head_q].write_enable;
    assign mem_out[k].addr         = buf_q[head_q].addr;
    assign mem_out[k].data         = buf_q[head_q].data;
    assign mem_out[k].id           = buf_q[head_q].id;
  end

`ifdef MEM_SPLIT_ID_CHECK_EN
  logic id_error_q;

  // Sticky: once a stray id has been swallowed only reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_error_q <= 1'b0;
    end else if (accept && !in_range) begin
      id_error_q <= 1'b1;
    end
  end

  assign id_error = id_error_q;
`else
  assign id_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_split.sv
// Self-checking bench for mem_split: directed vector table, queue-based
// reference model under random traffic, reset and id-range corner cases.
module tb_mem_split;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int IW = 1;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) in_if ();
  std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)) out_if [NP] ();
  logic id_error;

  mem_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW), .PORTS(NP)) dut (
    .clk(clk), .rst(rst), .mem_in(in_if), .mem_out(out_if), .id_error(id_error)
  );

  std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(2)) in3_if ();
  std_mem_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(2)) out3_if [3] ();
  logic id_error3;

  mem_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(2), .PORTS(3)) dut3 (
    .clk(clk), .rst(rst), .mem_in(in3_if), .mem_out(out3_if), .id_error(id_error3)
  );

  logic [NP-1:0] out_ready;
  logic [NP-1:0] ov;
  logic [DW-1:0] od  [NP];
  logic [AW-1:0] oa  [NP];
  logic [MW-1:0] ow  [NP];
  logic          ore [NP];
  logic [IW-1:0] oid [NP];

  for (genvar g = 0; g < NP; g++) begin : g_mon
    assign out_if[g].ready = out_ready[g];
    assign ov[g]  = out_if[g].valid;
    assign od[g]  = out_if[g].data;
    assign oa[g]  = out_if[g].addr;
    assign ow[g]  = out_if[g].write_enable;
    assign ore[g] = out_if[g].read_enable;
    assign oid[g] = out_if[g].id;
  end

  logic [2:0]    out3_ready;
  logic [2:0]    ov3;
  logic [DW-1:0] od3  [3];
  logic [1:0]    oid3 [3];

  for (genvar g = 0; g < 3; g++) begin : g_mon3
    assign out3_if[g].ready = out3_ready[g];
    assign ov3[g]  = out3_if[g].valid;
    assign od3[g]  = out3_if[g].data;
    assign oid3[g] = out3_if[g].id;
  end

  typedef struct packed {
    logic          re;
    logic [MW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } beat_t;

  typedef struct {
    logic          v;
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic [1:0]    rdy;
    logic          e_ready;
    logic [1:0]    e_valid;
    logic [DW-1:0] e_d0;
    logic [DW-1:0] e_d1;
  } vec_t;

  beat_t mq0[$];
  beat_t mq1[$];
  int    checks = 0;
  int    errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input beat_t b, input logic [1:0] rdy);
    in_if.valid        = v;
    in_if.read_enable  = b.re;
    in_if.write_enable = b.we;
    in_if.addr         = b.addr;
    in_if.data         = b.data;
    in_if.id           = b.id;
    out_ready          = rdy;
  endtask

  task automatic checkPort(input int k);
    int    sz;
    beat_t head;
    head = '0;
    if (k == 0) begin
      sz = mq0.size();
      if (sz > 0) head = mq0[0];
    end else begin
      sz = mq1.size();
      if (sz > 0) head = mq1[0];
    end
    checkOutput($sformatf("p%0d_valid", k), ov[k], sz != 0);
    if (sz != 0) begin
      checkOutput($sformatf("p%0d_data", k), od[k], head.data);
      checkOutput($sformatf("p%0d_addr", k), oa[k], head.addr);
      checkOutput($sformatf("p%0d_we", k), ow[k], head.we);
      checkOutput($sformatf("p%0d_re", k), ore[k], head.re);
      checkOutput($sformatf("p%0d_id", k), oid[k], head.id);
    end
  endtask

  // One clock of traffic against the queue model: the model decides accept and
  // pops from its own occupancy, then both sides are compared after the edge.
  task automatic modelCycle(input logic v, input beat_t b, input logic [1:0] rdy);
    logic acc;
    logic pop0;
    logic pop1;
    applyStimulus(v, b, rdy);
    acc  = v && (mq0.size() < 2) && (mq1.size() < 2);
    pop0 = rdy[0] && (mq0.size() > 0);
    pop1 = rdy[1] && (mq1.size() > 0);
    @(posedge clk);
    #1;
    if (pop0) void'(mq0.pop_front());
    if (pop1) void'(mq1.pop_front());
    if (acc) begin
      if (b.id == 0) mq0.push_back(b);
      else           mq1.push_back(b);
    end
    checkOutput("in_ready", in_if.ready, (mq0.size() < 2) && (mq1.size() < 2));
    checkPort(0);
    checkPort(1);
  endtask

  vec_t  vecs [13];
  beat_t b;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'hA5A5_0001, 2'b11, 1'b1, 2'b10, 32'h0, 32'hA5A5_0001};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'd1,         2'b11, 1'b1, 2'b01, 32'd1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'd2,         2'b11, 1'b1, 2'b10, 32'h0, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'd3,         2'b11, 1'b1, 2'b01, 32'd3, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'd4,         2'b11, 1'b1, 2'b10, 32'h0, 32'd4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'd1,         2'b10, 1'b1, 2'b01, 32'd1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd2,         2'b10, 1'b0, 2'b01, 32'd1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'd3,         2'b10, 1'b0, 2'b01, 32'd1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'd3,         2'b11, 1'b1, 2'b01, 32'd2, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'd3,         2'b11, 1'b1, 2'b01, 32'd3, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         2'b11, 1'b1, 2'b00, 32'h0, 32'h0};

    applyStimulus(1'b0, '0, 2'b00);
    in3_if.valid        = 1'b0;
    in3_if.read_enable  = 1'b0;
    in3_if.write_enable = '0;
    in3_if.addr         = '0;
    in3_if.data         = '0;
    in3_if.id           = '0;
    out3_ready          = 3'b111;

    #1;
    checkOutput("rst_ready", in_if.ready, 1'b0);
    checkOutput("rst_valid", ov, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_ready", in_if.ready, 1'b0);
    checkOutput("rst_data0", od[0], 32'h0);
    checkOutput("rst_data1", od[1], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release_ready", in_if.ready, 1'b1);
    checkOutput("release_valid", ov, 2'b00);

    for (int i = 0; i < 13; i++) begin
      b      = '0;
      b.id   = vecs[i].id;
      b.data = vecs[i].d;
      applyStimulus(vecs[i].v, b, vecs[i].rdy);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), in_if.ready, vecs[i].e_ready);
      checkOutput($sformatf("vec%0d_valid", i), ov, vecs[i].e_valid);
      if (vecs[i].e_valid[0]) checkOutput($sformatf("vec%0d_data0", i), od[0], vecs[i].e_d0);
      if (vecs[i].e_valid[1]) checkOutput($sformatf("vec%0d_data1", i), od[1], vecs[i].e_d1);
    end

    // Port 1 streams 16 beats while draining every cycle: occupancy stays at one.
    for (int i = 0; i < 16; i++) begin
      b      = '0;
      b.id   = 1'b1;
      b.data = 32'h100 + 32'(i);
      b.addr = 32'h2000 + 32'(i * 4);
      modelCycle(1'b1, b, 2'b11);
      checkOutput($sformatf("stream_data%0d", i), od[1], 32'h100 + 32'(i));
    end
    modelCycle(1'b0, '0, 2'b11);

    for (int i = 0; i < 600; i++) begin
      b.re   = 1'($urandom_range(0, 1));
      b.we   = MW'($urandom);
      b.addr = $urandom;
      b.data = $urandom;
      b.id   = IW'($urandom_range(0, 1));
      modelCycle(1'($urandom_range(0, 3) != 0), b,
                 {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6)});
    end
    repeat (4) modelCycle(1'b0, '0, 2'b11);

    b      = '0;
    b.data = 32'hDEAD_0000;
    modelCycle(1'b1, b, 2'b00);
    b.id   = 1'b1;
    b.data = 32'hDEAD_0001;
    modelCycle(1'b1, b, 2'b00);
    applyStimulus(1'b0, '0, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    mq0.delete();
    mq1.delete();
    checkOutput("midrst_valid", ov, 2'b00);
    checkOutput("midrst_ready", in_if.ready, 1'b0);
    checkOutput("midrst_data0", od[0], 32'h0);
    checkOutput("midrst_data1", od[1], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_release_ready", in_if.ready, 1'b1);
    checkOutput("midrst_release_valid", ov, 2'b00);
    repeat (3) modelCycle(1'b0, '0, 2'b11);

    in3_if.valid = 1'b1;
    in3_if.id    = 2'd3;
    in3_if.data  = 32'h3333_0003;
    checkOutput("p3_ready", in3_if.ready, 1'b1);
    @(posedge clk);
    #1;
    in3_if.valid = 1'b0;
`ifdef MEM_SPLIT_ID_CHECK_EN
    checkOutput("p3_oor_valid", ov3, 3'b000);
    checkOutput("p3_oor_err", id_error3, 1'b1);
`else
    checkOutput("p3_oor_valid", ov3, 3'b001);
    checkOutput("p3_oor_data", od3[0], 32'h3333_0003);
    checkOutput("p3_oor_id", oid3[0], 2'd3);
    checkOutput("p3_oor_err", id_error3, 1'b0);
`endif
    @(posedge clk);
    #1;
    checkOutput("p3_drained", ov3, 3'b000);
    in3_if.valid = 1'b1;
    in3_if.id    = 2'd2;
    in3_if.data  = 32'h2222_0002;
    @(posedge clk);
    #1;
    in3_if.valid = 1'b0;
    checkOutput("p3_port2_valid", ov3, 3'b100);
    checkOutput("p3_port2_data", od3[2], 32'h2222_0002);
`ifdef MEM_SPLIT_ID_CHECK_EN
    checkOutput("p3_err_sticky", id_error3, 1'b1);
`else
    checkOutput("p3_err_tied", id_error3, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("p3_err_reset", id_error3, 1'b0);
    checkOutput("p3_rst_valid", ov3, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("p2_id_error", id_error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
